// File: rtl/sr_strobe_gen_if.sv
// Button inputs and strobe/status outputs of the SR latch strobe generator.
interface sr_strobe_gen_if;
  logic btn_set;
  logic btn_reset;
  logic S_bar;
  logic R_bar;
  logic set_level;
  logic reset_level;
  logic busy;
  logic conflict;

  modport master (
    output btn_set, btn_reset,
    input  S_bar, R_bar, set_level, reset_level, busy, conflict
  );

  modport slave (
    input  btn_set, btn_reset,
    output S_bar, R_bar, set_level, reset_level, busy, conflict
  );
endinterface

// File: rtl/sr_strobe_gen.sv
// Debounces two raw buttons and issues fixed-width, mutually exclusive active-low
// set/reset strobes for a NAND SR latch; strobes are registered straight from the FSM.
module sr_strobe_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  sr_strobe_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_e;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES);
  localparam logic [3:0] PW_LAST = 4'(PULSE_CYCLES - 1);

  // Index 0 is the set button, index 1 the reset button.
  logic [1:0] btn;
  logic [1:0] sync1_q, sync2_q, lvl_q;
  logic [7:0] cnt_q [2];
  logic [1:0] toggle, rise;

  state_e     state_q;
  logic [3:0] pcnt_q;
  logic       s_bar_q, r_bar_q;
  logic       pend_s_q, pend_r_q;
  logic       busy_q, conflict_q;

  logic       ev_s, ev_r, start_s, start_r, can_start;
  logic       pend_s_d, pend_r_d, busy_d, conflict_d;

  assign btn = {bus.btn_reset, bus.btn_set};

  always_comb begin
    toggle = '0;
    rise   = '0;
    for (int i = 0; i < 2; i++) begin
      toggle[i] = (sync2_q[i] != lvl_q[i]) && (cnt_q[i] == DB_LAST);
      rise[i]   = toggle[i] && !lvl_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == lvl_q[i] || toggle[i]) cnt_q[i] <= '0;
        else                                     cnt_q[i] <= cnt_q[i] + 8'd1;
        if (toggle[i]) lvl_q[i] <= ~lvl_q[i];
      end
    end
  end

  // Simultaneous presses: reset wins and the set press is dropped outright.
  assign ev_r       = rise[1];
  assign ev_s       = rise[0] && !rise[1];
  assign conflict_d = rise[0] && rise[1];

  // GAP hands straight to the next pending pulse, so back-to-back service is
  // pulse+gap per strobe with no extra idle cycle in between.
  assign can_start = (state_q == IDLE) || (state_q == GAP);
  assign start_r   = can_start && pend_r_q;
  assign start_s   = can_start && !pend_r_q && pend_s_q;

  assign pend_r_d = (pend_r_q && !start_r) || ev_r;
  assign pend_s_d = (pend_s_q && !start_s) || ev_s;
  assign busy_d   = (state_q == PULSE_S) || (state_q == PULSE_R) ||
                    pend_r_q || pend_s_q || ev_r || ev_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      s_bar_q    <= 1'b1;
      r_bar_q    <= 1'b1;
      pend_s_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      pend_s_q   <= pend_s_d;
      pend_r_q   <= pend_r_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
      case (state_q)
        IDLE, GAP: begin
          pcnt_q <= '0;
          if (start_r) begin
            state_q <= PULSE_R;
            r_bar_q <= 1'b0;
          end else if (start_s) begin
            state_q <= PULSE_S;
            s_bar_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        PULSE_S, PULSE_R: begin
          if (pcnt_q == PW_LAST) begin
            state_q <= GAP;
            s_bar_q <= 1'b1;
            r_bar_q <= 1'b1;
          end else begin
            pcnt_q <= pcnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          s_bar_q <= 1'b1;
          r_bar_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.S_bar       = s_bar_q;
  assign bus.R_bar       = r_bar_q;
  assign bus.set_level   = lvl_q[0];
  assign bus.reset_level = lvl_q[1];
  assign bus.busy        = busy_q;
  assign bus.conflict    = conflict_q;

endmodule
